// File: rtl/sfp_pkg.sv
// Shared widths and field helpers for the SFP (sign/exp/significand) datapath.
package sfp_pkg;

  localparam int EXP_W      = 4;
  localparam int SIG_W      = 4;
  localparam int FMT_W      = 1 + EXP_W + SIG_W;
  localparam int LOW_EXPAND = 2;
  localparam int FIX_W      = SIG_W + 4 + LOW_EXPAND;
  localparam int MAG_W      = SIG_W + 1 + LOW_EXPAND;

  function automatic logic sfp_sign(input logic [FMT_W-1:0] w);
    return w[FMT_W-1];
  endfunction

  function automatic logic [EXP_W-1:0] sfp_exp(input logic [FMT_W-1:0] w);
    return w[FMT_W-2:SIG_W];
  endfunction

  function automatic logic [SIG_W-1:0] sfp_sig(input logic [FMT_W-1:0] w);
    return w[SIG_W-1:0];
  endfunction

endpackage

// File: rtl/sfp_align.sv
// Aligns one SFP operand to signed fixed point against a shared maximum exponent.
module sfp_align
  import sfp_pkg::*;
#(
  parameter int expWidth    = EXP_W,
  parameter int sigWidth    = SIG_W,
  parameter int formatWidth = FMT_W,
  parameter int low_expand  = LOW_EXPAND
) (
  input  logic [formatWidth-1:0]            sfp_i,
  input  logic [expWidth-1:0]               max_exp_i,
  output logic [sigWidth+4+low_expand-1:0]  fix_o
);

  localparam int MW = sigWidth + 1 + low_expand;
  localparam int FW = sigWidth + 4 + low_expand;

  logic                sign;
  logic [expWidth-1:0] exp_f;
  logic [sigWidth-1:0] sig_f;
  logic [expWidth-1:0] shamt;
  logic [MW-1:0]       mag_full;
  logic [MW-1:0]       mag_sh;
  logic [FW-1:0]       mag_ext;

  assign sign     = sfp_i[formatWidth-1];
  assign exp_f    = sfp_i[formatWidth-2:sigWidth];
  assign sig_f    = sfp_i[sigWidth-1:0];
  assign shamt    = max_exp_i - exp_f;
  assign mag_full = {1'b1, sig_f, {low_expand{1'b0}}};

  // Shifts at or beyond the magnitude width flush to zero (truncation, no rounding).
  assign mag_sh  = (32'(shamt) >= MW) ? '0 : (mag_full >> shamt);
  assign mag_ext = {{(FW-MW){1'b0}}, mag_sh};

  always_comb begin
    fix_o = '0;
    if (exp_f != '0) begin
      fix_o = sign ? (~mag_ext + 1'b1) : mag_ext;
    end
  end

endmodule

// File: rtl/hadamard4_align_add.sv
// Four-point Hadamard front end: max-exponent search, operand alignment and
// butterfly in a 3-stage valid/ready pipeline.
module hadamard4_align_add
  import sfp_pkg::*;
#(
  parameter int expWidth    = EXP_W,
  parameter int sigWidth    = SIG_W,
  parameter int formatWidth = FMT_W,
  parameter int low_expand  = LOW_EXPAND
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [4*formatWidth-1:0]            in_sfp,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [4*(sigWidth+4+low_expand)-1:0] out_fix,
  output logic [expWidth-1:0]                 out_max_exp
);

  localparam int W = sigWidth + 4 + low_expand;

  logic                     s1_v_q, s1_v_d;
  logic [4*formatWidth-1:0] s1_sfp_q;
  logic [expWidth-1:0]      s1_max_q, s1_max_d;

  logic                     s2_v_q, s2_v_d;
  logic [3:0][W-1:0]        s2_fix_q, s2_fix_d;
  logic [expWidth-1:0]      s2_max_q;

  logic                     s3_v_q, s3_v_d;
  logic [3:0][W-1:0]        s3_fix_q, s3_fix_d;
  logic [expWidth-1:0]      s3_max_q;

  logic ld1, ld2, ld3;

  assign ld3      = ~s3_v_q | out_ready;
  assign ld2      = ~s2_v_q | ld3;
  assign in_ready = ~s1_v_q | ld2;
  assign ld1      = in_ready;

  assign s1_v_d = ld1 ? in_valid : s1_v_q;
  assign s2_v_d = ld2 ? s1_v_q   : s2_v_q;
  assign s3_v_d = ld3 ? s2_v_q   : s3_v_q;

  // A zero operand has exp==0, so a plain max over raw exponents already excludes it.
  always_comb begin
    s1_max_d = '0;
    for (int k = 0; k < 4; k++) begin
      if (in_sfp[k*formatWidth+sigWidth +: expWidth] > s1_max_d) begin
        s1_max_d = in_sfp[k*formatWidth+sigWidth +: expWidth];
      end
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_align
    sfp_align #(
      .expWidth    (expWidth),
      .sigWidth    (sigWidth),
      .formatWidth (formatWidth),
      .low_expand  (low_expand)
    ) u_align (
      .sfp_i     (s1_sfp_q[k*formatWidth +: formatWidth]),
      .max_exp_i (s1_max_q),
      .fix_o     (s2_fix_d[k])
    );
  end

  always_comb begin
    s3_fix_d    = '0;
    s3_fix_d[0] = s2_fix_q[0] + s2_fix_q[1] + s2_fix_q[2] + s2_fix_q[3];
    s3_fix_d[1] = s2_fix_q[0] - s2_fix_q[1] + s2_fix_q[2] - s2_fix_q[3];
    s3_fix_d[2] = s2_fix_q[0] + s2_fix_q[1] - s2_fix_q[2] - s2_fix_q[3];
    s3_fix_d[3] = s2_fix_q[0] - s2_fix_q[1] - s2_fix_q[2] + s2_fix_q[3];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q   <= 1'b0;
      s1_sfp_q <= '0;
      s1_max_q <= '0;
      s2_v_q   <= 1'b0;
      s2_fix_q <= '0;
      s2_max_q <= '0;
      s3_v_q   <= 1'b0;
      s3_fix_q <= '0;
      s3_max_q <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      s3_v_q <= s3_v_d;
      if (ld1 && in_valid) begin
        s1_sfp_q <= in_sfp;
        s1_max_q <= s1_max_d;
      end
      if (ld2 && s1_v_q) begin
        s2_fix_q <= s2_fix_d;
        s2_max_q <= s1_max_q;
      end
      if (ld3 && s2_v_q) begin
        s3_fix_q <= s3_fix_d;
        s3_max_q <= s2_max_q;
      end
    end
  end

  assign out_valid   = s3_v_q;
  assign out_fix     = s3_fix_q;
  assign out_max_exp = s3_max_q;

endmodule
